// File: rtl/fifo_rr_arbiter_if.sv
// Producer-side and Fifo-side signals of the round-robin write-port arbiter.
// The slave modport is the arbiter's view; master is the view of whatever
// drives the producers and models the Fifo.
interface fifo_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int SIZE    = 32
);
    localparam int OWN_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]      req_valid_i;
    logic [NUM_REQ*SIZE-1:0] req_data_i;
    logic [NUM_REQ-1:0]      grant_o;
    logic [OWN_W-1:0]        owner_o;
    logic                    busy_o;
    logic                    fifo_valid_o;
    logic [SIZE-1:0]         fifo_data_o;
    logic                    fifo_full_i;

    modport slave (
        input  req_valid_i, req_data_i, fifo_full_i,
        output grant_o, owner_o, busy_o, fifo_valid_o, fifo_data_o
    );

    modport master (
        output req_valid_i, req_data_i, fifo_full_i,
        input  grant_o, owner_o, busy_o, fifo_valid_o, fifo_data_o
    );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one Fifo write port among NUM_REQ producers.
// A granted producer keeps the port for up to MAX_BURST accepted beats, or
// until it has no beat to offer; the next owner is chosen in the same cycle
// so back-to-back bursts carry no idle bubble.
module fifo_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int SIZE      = 32,
    parameter int MAX_BURST = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fifo_rr_arbiter_if.slave   bus
);
    localparam int OWN_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_OWN  = 1'b1;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    logic [0:0]       r_state;
    logic [OWN_W-1:0] r_owner;
    logic [OWN_W-1:0] r_rr_last;
    logic [CNT_W-1:0] r_beat_cnt;

    logic [OWN_W-1:0] w_base;
    logic [OWN_W-1:0] w_idx;
    logic [OWN_W-1:0] w_winner;
    logic             w_any;
    logic             w_own;
    logic             w_own_valid;
    logic             w_accept;
    logic             w_release;

    // While owning, a release hands priority on from the current owner;
    // while idle the search starts after the last recorded owner.
    assign w_own       = (r_state == S_OWN);
    assign w_base      = w_own ? r_owner : r_rr_last;
    assign w_own_valid = bus.req_valid_i[r_owner];
    assign w_accept    = w_own & w_own_valid & ~bus.fifo_full_i;
    assign w_release   = w_own & ((w_accept & (r_beat_cnt == LAST_BEAT)) | ~w_own_valid);

    // Round-robin search from w_base+1; scanning from farthest to nearest
    // lets the nearest requester overwrite the others and win.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_idx = OWN_W'((int'(w_base) + i) % NUM_REQ);
            if (bus.req_valid_i[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // One-hot grant to the owner, withdrawn while the Fifo is full.
    always_comb begin
        bus.grant_o = '0;
        if (w_own && !bus.fifo_full_i) begin
            bus.grant_o[r_owner] = 1'b1;
        end
    end

    // Zero-latency data path onto the Fifo write port; zero when nothing is written.
    always_comb begin
        bus.fifo_data_o = '0;
        if (w_accept) begin
            bus.fifo_data_o = bus.req_data_i[int'(r_owner)*SIZE +: SIZE];
        end
    end

    assign bus.fifo_valid_o = w_accept;
    assign bus.busy_o       = w_own;
    assign bus.owner_o      = r_owner;

    // Ownership, round-robin pointer and burst counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values together.
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_rr_last  <= OWN_W'(NUM_REQ - 1);
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state    <= S_OWN;
                        r_owner    <= w_winner;
                        r_beat_cnt <= '0;
                    end
                end
                default: begin
                    if (w_release) begin
                        r_rr_last  <= r_owner;
                        r_beat_cnt <= '0;
                        if (w_any) begin
                            r_owner <= w_winner;
                        end else begin
                            r_state <= S_IDLE;
                            r_owner <= '0;
                        end
                    end else if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
Round-robin arbiter that shares the write port of one Fifo instance among NUM_REQ producers. It grants one producer at a time and holds the grant for a burst of up to MAX_BURST beats. It muxes the owner's data onto the Fifo write port and stalls all producers while the Fifo reports full. It sits directly in front of the Fifo's valid_i/data_i/is_full_o.

Parameters:
NUM_REQ, 4, number of producers (2..16)
SIZE, 32, data width; must match the Fifo SIZE
MAX_BURST, 4, maximum accepted beats per grant (1..255)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-high reset
req_valid_i  input  NUM_REQ  per-producer beat valid
req_data_i  input  NUM_REQ*SIZE  producer k data at bits [k*SIZE +: SIZE]
grant_o  output  NUM_REQ  one-hot; beat of producer k is accepted when req_valid_i[k] & grant_o[k]
owner_o  output  $clog2(NUM_REQ)  current owner index; 0 when idle
busy_o  output  1  high while a producer owns the port
fifo_valid_o  output  1  drives Fifo valid_i
fifo_data_o  output  SIZE  drives Fifo data_i
fifo_full_i  input  1  from Fifo is_full_o

Behaviour:
- Registered state: fsm {IDLE, OWN}, owner index, last-owner pointer rr_last, beat counter beat_cnt of width $clog2(MAX_BURST+1).
- Reset (async, immediate):
  - fsm=IDLE, owner=0, beat_cnt=0.
  - rr_last=NUM_REQ-1, so producer 0 has first priority.
  - All outputs 0: grant_o, busy_o, fifo_valid_o and fifo_data_o, the last two combinationally.
- Arbitration:
  - Search order is rr_last+1, rr_last+2, … modulo NUM_REQ.
  - The first k with req_valid_i[k]=1 wins.
  - The previous owner therefore has the lowest priority but can win again if it is the only requester.
- IDLE:
  - grant_o=0.
  - If any req_valid_i is set, the winner is registered at the edge: fsm→OWN, owner=winner, beat_cnt=0.
  - Grant latency from an IDLE request is 1 cycle.
- OWN:
  - grant_o[owner] = !fifo_full_i; busy_o=1.
  - Accept = req_valid_i[owner] & !fifo_full_i.
  - fifo_valid_o = accept and fifo_data_o = req_data_i[owner], combinational with zero latency.
  - When no beat is accepted, fifo_data_o=0.
  - On each accept, beat_cnt increments.
- Release from OWN happens at the edge when either condition holds:
  - (a) an accept occurs with beat_cnt==MAX_BURST-1;
  - (b) req_valid_i[owner]==0, i.e. the producer has no beat this cycle.
- On release:
  - rr_last=owner.
  - Arbitration runs in the same cycle over current req_valid_i, with the owner included at lowest priority, and its winner is registered directly into OWN with beat_cnt=0 (no IDLE bubble).
  - If there is no requester, fsm→IDLE.
- Full stall:
  - While fifo_full_i=1 in OWN, nothing is accepted and the grant is held.
  - beat_cnt is unchanged and there is no release unless req_valid_i[owner] drops.
  - There is no timeout.
- Producers must hold req_valid_i and data stable until accepted. Data of non-owners is ignored.
- Never more than one grant_o bit is set. fifo_valid_o=1 never coincides with fifo_full_i=1.
- MAX_BURST=1 gives strict per-beat round-robin.
- Reset asserted mid-burst: grant and fifo_valid_o drop in the same cycle, and the beat in flight is not written.

Test Plan:
- Reset, then req_valid_i=4'b0001 constantly → grant_o=0001 from the 2nd cycle. Bursts of 4 beats, then producer 0 is re-granted with no bubble because it is the sole requester.
- req_valid_i=4'b1111 held, MAX_BURST=4, fifo_full_i=0 → owners 0,1,2,3,0 each receive exactly 4 beats. fifo_valid_o stays high continuously after the first grant.
- Producer 2 owns with beat_cnt=1 when fifo_full_i rises for 5 cycles → grant_o=0 and fifo_valid_o=0 for those 5 cycles. The remaining 3 beats are then accepted and owner=2 throughout.
- Producer 1 owns and deasserts req_valid_i after 2 beats while producer 3 is requesting → owner becomes 3 on the next cycle. Producer 1 is not re-granted before producer 3 finishes.
- rst_i pulsed mid-burst, asynchronously between edges → grant_o, busy_o and fifo_valid_o go to 0 before the next edge. After release, producer 0 wins first with all requesting.
- Data check → each producer sends an incrementing pattern 0xk000_0000+n. The Fifo read-out order matches grant order, with no loss or duplication over 1000 random-valid cycles.
